// File: rtl/vga_pattern_gen.sv
//============================================================================
// Module      : vga_pattern_gen
// Description : Pixel source placed after the VGA timing generator. Produces
//               a 12-bit RGB stream (solid, colour bars, checkerboard or
//               bouncing box) through a 2-stage pipeline. The syncs are
//               delayed by the same 2 cycles so they stay aligned with pixels.
// Macro       : VGA_PATTERN_BOX_EN - when defined, mode 3 is the bouncing
//               box; when undefined, mode 3 is black and no box logic exists.
// Ports       :
//   clk_i          in   pixel clock
//   arstn_i        in   asynchronous active-low reset
//   hcount_i       in   horizontal counter
//   vcount_i       in   vertical counter
//   pixel_enable_i in   active-area flag
//   hs_i / vs_i    in   syncs from timing generator (active-low)
//   hd_i / vd_i    in   active width / height (box bounce limits)
//   mode_i         in   pattern select (captured once per frame)
//   color_i        in   user colour (used live)
//   rgb_o          out  pixel to DAC
//   vga_hs_o/vs_o  out  syncs delayed by 2 cycles
//   frame_cnt_o    out  frame counter, wraps 255 -> 0
// Revision    : 1.0 - initial release
//============================================================================
`timescale 1ns/1ps
`default_nettype none

module vga_pattern_gen #(
   parameter int VGA_MAX_H_WIDTH = 11,
   parameter int VGA_MAX_V_WIDTH = 10,
   parameter int BOX_SIZE        = 32,
   parameter int STEP            = 2,
   parameter int BAR_SHIFT       = 6,
   parameter int CHK_SHIFT       = 4
) (
   input  logic                       clk_i,
   input  logic                       arstn_i,
   input  logic [VGA_MAX_H_WIDTH-1:0] hcount_i,
   input  logic [VGA_MAX_V_WIDTH-1:0] vcount_i,
   input  logic                       pixel_enable_i,
   input  logic                       hs_i,
   input  logic                       vs_i,
   input  logic [VGA_MAX_H_WIDTH-1:0] hd_i,
   input  logic [VGA_MAX_V_WIDTH-1:0] vd_i,
   input  logic [1:0]                 mode_i,
   input  logic [11:0]                color_i,
   output logic [11:0]                rgb_o,
   output logic                       vga_hs_o,
   output logic                       vga_vs_o,
   output logic [7:0]                 frame_cnt_o
);

   localparam int HW = VGA_MAX_H_WIDTH;
   localparam int VW = VGA_MAX_V_WIDTH;

   // Stage 1 holds the derived pattern terms rather than the raw counters:
   // only the bar index, checker bit and box hit are needed by stage 2.
   logic       r_pe;
   logic       r_hs;
   logic       r_vs;
   logic [2:0] r_bar;
   logic       r_chk;
   logic       r_hit;
   logic [1:0] r_mode;
   logic       w_tick;
   logic       w_hit;
   logic [11:0] w_pix;

   // vga_vs_o is the previous stage-1 vsync, so this is the registered
   // falling edge of vs_i, one cycle after vs_i drops.
   assign w_tick = vga_vs_o & ~r_vs;

`ifdef VGA_PATTERN_BOX_EN
   localparam logic [0:0]  c_FWD   = 1'b0;
   localparam logic [0:0]  c_BACK  = 1'b1;
   localparam logic [HW:0] c_BOX_H  = (HW+1)'(BOX_SIZE);
   localparam logic [HW:0] c_STEP_H = (HW+1)'(STEP);
   localparam logic [VW:0] c_BOX_V  = (VW+1)'(BOX_SIZE);
   localparam logic [VW:0] c_STEP_V = (VW+1)'(STEP);

   logic [HW-1:0] r_x, w_x_nxt;
   logic [VW-1:0] r_y, w_y_nxt;
   logic [0:0]    r_xst, w_xst_nxt;
   logic [0:0]    r_yst, w_yst_nxt;
   logic [HW:0]   w_x_ext, w_hd_ext, w_h_ext;
   logic [VW:0]   w_y_ext, w_vd_ext, w_v_ext;

   // One extra bit on every sum/compare so pos+BOX_SIZE+STEP cannot wrap.
   assign w_x_ext  = {1'b0, r_x};
   assign w_hd_ext = {1'b0, hd_i};
   assign w_h_ext  = {1'b0, hcount_i};
   assign w_y_ext  = {1'b0, r_y};
   assign w_vd_ext = {1'b0, vd_i};
   assign w_v_ext  = {1'b0, vcount_i};

   always_comb begin
      w_x_nxt   = r_x;
      w_xst_nxt = r_xst;
      if (w_hd_ext < c_BOX_H) begin
         w_x_nxt = '0;                       // box cannot fit: park at 0
      end else if (r_xst == c_FWD) begin
         if (w_x_ext + c_BOX_H + c_STEP_H > w_hd_ext) begin
            w_x_nxt   = HW'(w_hd_ext - c_BOX_H);
            w_xst_nxt = c_BACK;
         end else begin
            w_x_nxt = HW'(w_x_ext + c_STEP_H);
         end
      end else begin
         if (w_x_ext < c_STEP_H) begin
            w_x_nxt   = '0;
            w_xst_nxt = c_FWD;
         end else begin
            w_x_nxt = HW'(w_x_ext - c_STEP_H);
         end
      end
   end

   always_comb begin
      w_y_nxt   = r_y;
      w_yst_nxt = r_yst;
      if (w_vd_ext < c_BOX_V) begin
         w_y_nxt = '0;
      end else if (r_yst == c_FWD) begin
         if (w_y_ext + c_BOX_V + c_STEP_V > w_vd_ext) begin
            w_y_nxt   = VW'(w_vd_ext - c_BOX_V);
            w_yst_nxt = c_BACK;
         end else begin
            w_y_nxt = VW'(w_y_ext + c_STEP_V);
         end
      end else begin
         if (w_y_ext < c_STEP_V) begin
            w_y_nxt   = '0;
            w_yst_nxt = c_FWD;
         end else begin
            w_y_nxt = VW'(w_y_ext - c_STEP_V);
         end
      end
   end

   always_ff @(posedge clk_i or negedge arstn_i) begin
      if (!arstn_i) begin
         r_x   <= '0;
         r_y   <= '0;
         r_xst <= c_FWD;
         r_yst <= c_FWD;
      end else if (w_tick) begin
         r_x   <= w_x_nxt;
         r_y   <= w_y_nxt;
         r_xst <= w_xst_nxt;
         r_yst <= w_yst_nxt;
      end
   end

   assign w_hit = (w_h_ext >= w_x_ext) && (w_h_ext < w_x_ext + c_BOX_H) &&
                  (w_v_ext >= w_y_ext) && (w_v_ext < w_y_ext + c_BOX_V);
`else
   logic w_unused_box;
   assign w_unused_box = ^{hcount_i, vcount_i, hd_i, vd_i};
   assign w_hit        = 1'b0;
`endif

   // Stage 1: register pipeline flags and the per-pixel pattern terms.
   always_ff @(posedge clk_i or negedge arstn_i) begin
      if (!arstn_i) begin
         r_pe  <= 1'b0;
         r_hs  <= 1'b1;
         r_vs  <= 1'b1;
         r_bar <= 3'd0;
         r_chk <= 1'b0;
         r_hit <= 1'b0;
      end else begin
         r_pe  <= pixel_enable_i;
         r_hs  <= hs_i;
         r_vs  <= vs_i;
         r_bar <= hcount_i[BAR_SHIFT+2:BAR_SHIFT];
         r_chk <= hcount_i[CHK_SHIFT] ^ vcount_i[CHK_SHIFT];
         r_hit <= w_hit;
      end
   end

   // Mode and frame counter only move on the frame tick so a pattern
   // change never tears mid-frame.
   always_ff @(posedge clk_i or negedge arstn_i) begin
      if (!arstn_i) begin
         r_mode      <= 2'd0;
         frame_cnt_o <= 8'd0;
      end else if (w_tick) begin
         r_mode      <= mode_i;
         frame_cnt_o <= frame_cnt_o + 8'd1;
      end
   end

   always_comb begin
      w_pix = 12'h000;
      case (r_mode)
         2'd0: w_pix = color_i;
         2'd1: begin
            case (r_bar)
               3'd0:    w_pix = 12'hFFF;
               3'd1:    w_pix = 12'hFF0;
               3'd2:    w_pix = 12'h0FF;
               3'd3:    w_pix = 12'h0F0;
               3'd4:    w_pix = 12'hF0F;
               3'd5:    w_pix = 12'hF00;
               3'd6:    w_pix = 12'h00F;
               default: w_pix = 12'h000;
            endcase
         end
         2'd2:    w_pix = r_chk ? color_i : 12'h000;
         default: w_pix = r_hit ? color_i : 12'h000;
      endcase
   end

   // Stage 2: output registers, blanked outside the active area.
   always_ff @(posedge clk_i or negedge arstn_i) begin
      if (!arstn_i) begin
         rgb_o    <= 12'h000;
         vga_hs_o <= 1'b1;
         vga_vs_o <= 1'b1;
      end else begin
         rgb_o    <= r_pe ? w_pix : 12'h000;
         vga_hs_o <= r_hs;
         vga_vs_o <= r_vs;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_vga_pattern_gen.sv
//============================================================================
// Module      : tb_vga_pattern_gen
// Description : Directed self-checking bench for vga_pattern_gen. Drives the
//               counters directly; frame ticks are made with short vsync
//               pulses. Box expectations follow VGA_PATTERN_BOX_EN.
// Revision    : 1.0 - initial release
//============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_vga_pattern_gen;

   logic        clk = 1'b0;
   logic        arstn_i;
   logic [10:0] hcount_i;
   logic [9:0]  vcount_i;
   logic        pixel_enable_i;
   logic        hs_i;
   logic        vs_i;
   logic [10:0] hd_i;
   logic [9:0]  vd_i;
   logic [1:0]  mode_i;
   logic [11:0] color_i;
   logic [11:0] rgb_o;
   logic        vga_hs_o;
   logic        vga_vs_o;
   logic [7:0]  frame_cnt_o;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   vga_pattern_gen dut (
      .clk_i          (clk),
      .arstn_i        (arstn_i),
      .hcount_i       (hcount_i),
      .vcount_i       (vcount_i),
      .pixel_enable_i (pixel_enable_i),
      .hs_i           (hs_i),
      .vs_i           (vs_i),
      .hd_i           (hd_i),
      .vd_i           (vd_i),
      .mode_i         (mode_i),
      .color_i        (color_i),
      .rgb_o          (rgb_o),
      .vga_hs_o       (vga_hs_o),
      .vga_vs_o       (vga_vs_o),
      .frame_cnt_o    (frame_cnt_o)
   );

   task automatic check_value(input string tag, input logic [31:0] obs,
                              input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Present one pixel and wait for it to reach rgb_o.
   task automatic pix(input int h, input int v, input logic pe);
      hcount_i       = h[10:0];
      vcount_i       = v[9:0];
      pixel_enable_i = pe;
      step();
      step();
   endtask

   task automatic frame_tick(input logic [1:0] m);
      pixel_enable_i = 1'b0;
      mode_i         = m;
      vs_i           = 1'b0;
      step();
      vs_i = 1'b1;
      step();
      step();
   endtask

   int          xs [6] = '{2, 4, 6, 8, 8, 6};
   logic [11:0] box_c;

   initial begin
      arstn_i = 1'b0; hcount_i = '0; vcount_i = '0; pixel_enable_i = 1'b0;
      hs_i = 1'b1; vs_i = 1'b1; hd_i = 11'd640; vd_i = 10'd480;
      mode_i = 2'd0; color_i = 12'hA5C;
`ifdef VGA_PATTERN_BOX_EN
      box_c = 12'hA5C;
`else
      box_c = 12'h000;
`endif
      step(); step();
      check_value("rst_rgb", 32'(rgb_o), 32'h000);
      check_value("rst_hs", 32'(vga_hs_o), 32'h1);
      check_value("rst_vs", 32'(vga_vs_o), 32'h1);
      check_value("rst_frame", 32'(frame_cnt_o), 32'h0);
      arstn_i = 1'b1;
      step();

      // Pixel and hsync alignment: exactly 2 cycles
      pixel_enable_i = 1'b1; hcount_i = 11'd0; hs_i = 1'b0;
      step();
      check_value("align_rgb_n1", 32'(rgb_o), 32'h000);
      check_value("align_hs_n1", 32'(vga_hs_o), 32'h1);
      step();
      check_value("align_rgb_n2", 32'(rgb_o), 32'hA5C);
      check_value("align_hs_n2", 32'(vga_hs_o), 32'h0);
      hs_i = 1'b1;

      // Vsync alignment and frame tick selecting colour bars
      pixel_enable_i = 1'b0; mode_i = 2'd1; vs_i = 1'b0;
      step();
      check_value("vs_n1", 32'(vga_vs_o), 32'h1);
      vs_i = 1'b1;
      step();
      check_value("vs_n2", 32'(vga_vs_o), 32'h0);
      step();
      check_value("vs_n3", 32'(vga_vs_o), 32'h1);
      check_value("frame_1", 32'(frame_cnt_o), 32'h1);

      pix(0, 0, 1'b1);   check_value("bar_0", 32'(rgb_o), 32'hFFF);
      pix(64, 0, 1'b1);  check_value("bar_64", 32'(rgb_o), 32'hFF0);
      pix(128, 0, 1'b1); check_value("bar_128", 32'(rgb_o), 32'h0FF);
      pix(256, 0, 1'b1); check_value("bar_256", 32'(rgb_o), 32'hF0F);
      pix(320, 0, 1'b1); check_value("bar_320", 32'(rgb_o), 32'hF00);
      pix(448, 0, 1'b1); check_value("bar_448", 32'(rgb_o), 32'h000);
      pix(64, 0, 1'b0);  check_value("bar_blank", 32'(rgb_o), 32'h000);

      // Mode change mid-frame is deferred to the next tick
      mode_i = 2'd2;
      pix(64, 100, 1'b1);  check_value("midframe_bar", 32'(rgb_o), 32'hFF0);
      pix(192, 100, 1'b1); check_value("midframe_bar3", 32'(rgb_o), 32'h0F0);
      frame_tick(2'd2);
      check_value("frame_2", 32'(frame_cnt_o), 32'h2);
      pix(16, 0, 1'b1);  check_value("chk_16_0", 32'(rgb_o), 32'hA5C);
      pix(16, 16, 1'b1); check_value("chk_16_16", 32'(rgb_o), 32'h000);
      pix(0, 0, 1'b1);   check_value("chk_0_0", 32'(rgb_o), 32'h000);
      pix(0, 16, 1'b1);  check_value("chk_0_16", 32'(rgb_o), 32'hA5C);

      // Asynchronous reset mid-line
      hcount_i = 11'd16; vcount_i = 10'd0; pixel_enable_i = 1'b1; hs_i = 1'b0;
      step(); step();
      check_value("pre_rst_hs", 32'(vga_hs_o), 32'h0);
      #2 arstn_i = 1'b0;
      #1;
      check_value("mid_rst_rgb", 32'(rgb_o), 32'h000);
      check_value("mid_rst_hs", 32'(vga_hs_o), 32'h1);
      check_value("mid_rst_frame", 32'(frame_cnt_o), 32'h0);
      step();
      arstn_i = 1'b1; hs_i = 1'b1;
      pix(16, 16, 1'b1); check_value("post_rst_mode0", 32'(rgb_o), 32'hA5C);

      // Bouncing box, hd_i = 40
      hd_i = 11'd40;
      for (int k = 0; k < 6; k++) begin
         int x, y;
         frame_tick(2'd3);
         x = xs[k];
         y = 2 * (k + 1);
         pix(x, y, 1'b1);      check_value("box_in", 32'(rgb_o), 32'(box_c));
         pix(x + 31, y, 1'b1); check_value("box_right_in", 32'(rgb_o), 32'(box_c));
         pix(x + 32, y, 1'b1); check_value("box_right_out", 32'(rgb_o), 32'h000);
         pix(x - 1, y, 1'b1);  check_value("box_left_out", 32'(rgb_o), 32'h000);
         pix(x, y - 1, 1'b1);  check_value("box_top_out", 32'(rgb_o), 32'h000);
         pix(x, y + 31, 1'b1); check_value("box_bot_in", 32'(rgb_o), 32'(box_c));
         pix(x, y + 32, 1'b1); check_value("box_bot_out", 32'(rgb_o), 32'h000);
      end
      check_value("frame_6", 32'(frame_cnt_o), 32'h6);

      // Active width smaller than the box: x parks at 0
      hd_i = 11'd20;
      frame_tick(2'd3);
      pix(0, 14, 1'b1);  check_value("small_in", 32'(rgb_o), 32'(box_c));
      pix(31, 14, 1'b1); check_value("small_edge", 32'(rgb_o), 32'(box_c));
      pix(32, 14, 1'b1); check_value("small_out", 32'(rgb_o), 32'h000);

      // Frame counter wrap
      for (int i = 0; i < 248; i++) frame_tick(2'd0);
      check_value("frame_255", 32'(frame_cnt_o), 32'hFF);
      frame_tick(2'd0);
      check_value("frame_wrap", 32'(frame_cnt_o), 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

`default_nettype wire
